// File: rtl/joypad_poll_ctrl_pkg.sv
// Shared constants for the joypad controller: P1 address, button bit indices,
// FSM encodings and the P1 nibble mux used by the register read view.
package joypad_poll_ctrl_pkg;

   localparam logic [15:0] P1_ADDR = 16'hFF00;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LATCH    = 3'd1;
   localparam logic [2:0] ST_PULSE_HI = 3'd2;
   localparam logic [2:0] ST_PULSE_LO = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Active-low nibble: a cleared sel bit enables its group onto the nibble.
   function automatic logic [3:0] p1_nib(input logic [1:0] sel, input logic [7:0] b);
      logic [3:0] dir;
      logic [3:0] btn;
      logic [3:0] nib;
      dir = ~{b[BTN_DOWN], b[BTN_UP], b[BTN_LEFT], b[BTN_RIGHT]};
      btn = ~{b[BTN_START], b[BTN_SELECT], b[BTN_B], b[BTN_A]};
      nib = 4'hF;
      if (!sel[0]) nib = nib & dir;
      if (!sel[1]) nib = nib & btn;
      return nib;
   endfunction

endpackage

// File: rtl/joypad_poll_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous header inputs, with a selectable
// reset level so idle-high lines do not glitch low out of reset.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/joypad_poll_ctrl.sv
// Polls an NES-style serial pad on the header and presents the result through
// the Game Boy P1/JOYP register view, with a falling-edge joypad interrupt.
module joypad_poll_ctrl
   import joypad_poll_ctrl_pkg::*;
#(
   parameter int HALF_CYC    = 4,
   parameter int POLL_PERIOD = 200,
   parameter int NUM_BITS    = 8
) (
   input  logic                clock,
   input  logic                reset,
   output logic                latch,
   output logic                pulse,
   input  logic                data,
   input  logic                p1_we,
   input  logic [1:0]          p1_wdata,
   output logic [7:0]          p1_rdata,
   output logic [NUM_BITS-1:0] buttons,
   output logic                poll_done,
   output logic                joypad_irq
);

   localparam int PH_W  = $clog2(2*HALF_CYC);
   localparam int IDX_W = $clog2(NUM_BITS);
   localparam int CNT_W = $clog2(POLL_PERIOD);
   localparam int NV    = (NUM_BITS < 8) ? NUM_BITS : 8;

   localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2*HALF_CYC-1);
   localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CYC-1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS-1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POLL_PERIOD-1);

   logic                data_s;
   logic [CNT_W-1:0]    poll_cnt;
   logic [2:0]          state;
   logic [PH_W-1:0]     phase;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    samp_idx;
   logic                samp;
   logic                poll_start;
   logic [NUM_BITS-1:0] shift;
   logic [1:0]          sel;
   logic [7:0]          btn8;
   logic [3:0]          nib;
   logic [3:0]          prev_nib;

   sync2 #(.RST_VAL(1'b1)) u_sync_data (
      .clock (clock),
      .reset (reset),
      .d     (data),
      .q     (data_s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                 poll_cnt <= '0;
      else if (poll_cnt == CNT_LAST) poll_cnt <= '0;
      else                       poll_cnt <= poll_cnt + 1'b1;
   end

   // A start that arrives while a poll is still running is simply dropped.
   assign poll_start = (poll_cnt == CNT_LAST) && (state == ST_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         phase <= '0;
         idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               phase <= '0;
               if (poll_start) state <= ST_LATCH;
            end
            ST_LATCH: begin
               if (phase == LATCH_LAST) begin
                  state <= ST_PULSE_HI;
                  phase <= '0;
                  idx   <= IDX_W'(1);
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_PULSE_HI: begin
               if (phase == HALF_LAST) begin
                  state <= ST_PULSE_LO;
                  phase <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_PULSE_LO: begin
               if (phase == HALF_LAST) begin
                  phase <= '0;
                  if (idx == IDX_LAST) begin
                     state <= ST_DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= ST_PULSE_HI;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign latch     = (state == ST_LATCH);
   assign pulse     = (state == ST_PULSE_HI);
   assign poll_done = (state == ST_DONE);

   // Bit 0 is valid while latch is high; later bits on the last low half of each pulse.
   assign samp     = ((state == ST_LATCH) && (phase == LATCH_LAST)) ||
                     ((state == ST_PULSE_LO) && (phase == HALF_LAST));
   assign samp_idx = (state == ST_LATCH) ? '0 : idx;

   always_ff @(posedge clock) begin
      if (samp) shift[samp_idx] <= data_s;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                  buttons <= '0;
      else if (state == ST_DONE)  buttons <= ~shift;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)      sel <= 2'b11;
      else if (p1_we) sel <= p1_wdata;
   end

   always_comb begin
      btn8         = '0;
      btn8[NV-1:0] = buttons[NV-1:0];
   end

   assign nib      = p1_nib(sel, btn8);
   assign p1_rdata = {2'b11, sel, nib};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_nib   <= 4'hF;
         joypad_irq <= 1'b0;
      end else begin
         prev_nib   <= nib;
         joypad_irq <= |(prev_nib & ~nib);
      end
   end

endmodule

// File: tb/tb_joypad_poll_ctrl.sv
// Directed bench for joypad_poll_ctrl with a behavioural NES pad model.
module tb_joypad_poll_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       latch;
   logic       pulse;
   logic       data;
   logic       p1_we = 1'b0;
   logic [1:0] p1_wdata = 2'b11;
   logic [7:0] p1_rdata;
   logic [7:0] buttons;
   logic       poll_done;
   logic       joypad_irq;

   int n_chk  = 0;
   int n_fail = 0;
   int irq_cnt = 0;
   int last_wait = 0;

   logic [7:0] pat_r = 8'hFF;
   logic       glitch = 1'b0;
   int         bitpos = 0;

   bit lat_a [72];
   bit pul_a [72];
   bit done_a[72];
   bit irq_a [72];

   typedef struct packed {
      logic [7:0] pat;
      logic [1:0] sel;
      logic [7:0] btn;
      logic [7:0] rd;
   } vec_t;
   vec_t tbl[8];

   joypad_poll_ctrl #(.HALF_CYC(4), .POLL_PERIOD(200), .NUM_BITS(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .latch      (latch),
      .pulse      (pulse),
      .data       (data),
      .p1_we      (p1_we),
      .p1_wdata   (p1_wdata),
      .p1_rdata   (p1_rdata),
      .buttons    (buttons),
      .poll_done  (poll_done),
      .joypad_irq (joypad_irq)
   );

   always #5 clock = ~clock;

   // Pad model: latch reloads bit 0, each pulse rising edge advances one bit.
   always @(posedge latch or posedge pulse) begin
      if (latch) bitpos = 0;
      else       bitpos = bitpos + 1;
   end

   always_comb begin
      data = (bitpos < 8) ? pat_r[bitpos[2:0]] : 1'b1;
      if (glitch) data = ~data;
   end

   always @(negedge clock) if (joypad_irq === 1'b1) irq_cnt = irq_cnt + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic write_sel(input logic [1:0] s);
      p1_we = 1'b1;
      p1_wdata = s;
      tick();
      p1_we = 1'b0;
   endtask

   task automatic wait_latch(output bit ok);
      ok = 1'b0;
      for (int i = 1; i <= 400; i++) begin
         tick();
         if (latch === 1'b1) begin
            last_wait = i;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk = n_chk + 1;
         n_fail = n_fail + 1;
         $display("FAIL latch_timeout: no latch within 400 cycles");
      end
   endtask

   // Records one poll from the first latch-high cycle; optional one-cycle glitch
   // goff cycles after the falling edge of pulse number gbit.
   task automatic run_poll(input logic [7:0] pat, input int gbit, input int goff);
      int falls;
      int fall_c;
      bit ok;
      pat_r = pat;
      wait_latch(ok);
      if (!ok) return;
      falls = 0;
      fall_c = -100;
      for (int c = 0; c < 72; c++) begin
         lat_a[c]  = latch;
         pul_a[c]  = pulse;
         done_a[c] = poll_done;
         irq_a[c]  = joypad_irq;
         if (c > 0 && pul_a[c-1] && !pulse) begin
            falls = falls + 1;
            if (falls == gbit) fall_c = c;
         end
         if (c == fall_c + goff)          glitch = 1'b1;
         else if (c == fall_c + goff + 1) glitch = 1'b0;
         tick();
      end
      glitch = 1'b0;
   endtask

   task automatic check_timing();
      int lc;
      int pe;
      int bad;
      int dn;
      bit e;
      lc = 0; pe = 0; bad = 0; dn = 0;
      for (int c = 0; c < 72; c++) begin
         lc = lc + int'(lat_a[c]);
         dn = dn + int'(done_a[c]);
         e = (c >= 8) && (c < 64) && (((c - 8) % 8) < 4);
         if (pul_a[c] != e) bad = bad + 1;
         if (c > 0 && pul_a[c] && !pul_a[c-1]) pe = pe + 1;
      end
      chk("latch_cycles", lc, 8);
      chk("latch_low_at_8", int'(lat_a[8]), 0);
      chk("pulse_count", pe, 7);
      chk("pulse_shape_errs", bad, 0);
      chk("done_at_64", int'(done_a[64]), 1);
      chk("done_count", dn, 1);
   endtask

   initial begin
      bit ok;
      int falls;
      int s0;
      bit prev;

      tbl[0] = '{8'hFE, 2'b11, 8'h01, 8'hFF};
      tbl[1] = '{8'h7F, 2'b10, 8'h80, 8'hEE};
      tbl[2] = '{8'h7F, 2'b01, 8'h80, 8'hDF};
      tbl[3] = '{8'h7F, 2'b11, 8'h80, 8'hFF};
      tbl[4] = '{8'h00, 2'b00, 8'hFF, 8'hC0};
      tbl[5] = '{8'hAA, 2'b10, 8'h55, 8'hE9};
      tbl[6] = '{8'hAA, 2'b01, 8'h55, 8'hDA};
      tbl[7] = '{8'hAA, 2'b00, 8'h55, 8'hC8};

      // Bring-up: reset, run part of a count, reset again mid-count.
      repeat (3) tick();
      reset = 1'b0;
      repeat (37) tick();
      #3 reset = 1'b1;
      #1;
      chk("rst_latch", int'(latch), 0);
      chk("rst_pulse", int'(pulse), 0);
      chk("rst_buttons", int'(buttons), 8'h00);
      chk("rst_p1_rdata", int'(p1_rdata), 8'hFF);
      chk("rst_poll_done", int'(poll_done), 0);
      chk("rst_irq", int'(joypad_irq), 0);
      repeat (2) tick();

      // First poll after release, then reset while in PULSE_LO with idx 4.
      pat_r = 8'hFE;
      @(negedge clock) reset = 1'b0;
      wait_latch(ok);
      chk("first_poll_start", last_wait, 200);
      falls = 0;
      prev = pulse;
      for (int i = 0; i < 80 && falls < 4; i++) begin
         tick();
         if (prev && !pulse) falls = falls + 1;
         prev = pulse;
      end
      chk("reach_pulse_lo_idx4", falls, 4);
      #3 reset = 1'b1;
      #1;
      chk("midpoll_latch", int'(latch), 0);
      chk("midpoll_pulse", int'(pulse), 0);
      repeat (3) tick();
      chk("midpoll_buttons", int'(buttons), 8'h00);
      @(negedge clock) reset = 1'b0;

      run_poll(8'hFE, 0, 0);
      chk("wrap_after_reset", last_wait, 200);
      check_timing();
      chk("a_pressed_buttons", int'(buttons), 8'h01);

      for (int i = 0; i < 8; i++) begin
         write_sel(tbl[i].sel);
         run_poll(tbl[i].pat, 0, 0);
         chk($sformatf("vec%0d_buttons", i), int'(buttons), int'(tbl[i].btn));
         chk($sformatf("vec%0d_p1_rdata", i), int'(p1_rdata), int'(tbl[i].rd));
      end

      // Interrupt on Start press with the button group selected.
      run_poll(8'hFF, 0, 0);
      write_sel(2'b01);
      repeat (3) tick();
      s0 = irq_cnt;
      run_poll(8'hF7, 0, 0);
      chk("irq_start_count", irq_cnt - s0, 1);
      chk("irq_start_cycle66", int'(irq_a[66]), 1);
      chk("irq_start_p1_rdata", int'(p1_rdata), 8'hD7);
      s0 = irq_cnt;
      run_poll(8'hF7, 0, 0);
      chk("irq_repeat_count", irq_cnt - s0, 0);

      // Interrupt caused only by a select write.
      s0 = irq_cnt;
      write_sel(2'b11);
      repeat (3) tick();
      write_sel(2'b01);
      repeat (3) tick();
      chk("irq_sel_write", irq_cnt - s0, 1);

      // Glitch 3 cycles before the bit-3 sample must vanish; 2 cycles before lands.
      write_sel(2'b11);
      run_poll(8'hFF, 3, 0);
      chk("glitch_early_buttons", int'(buttons), 8'h00);
      run_poll(8'hFF, 3, 1);
      chk("glitch_late_buttons", int'(buttons), 8'h08);

      // Asynchronous drop of latch and pulse when reset arrives between edges.
      wait_latch(ok);
      #3 reset = 1'b1;
      #1;
      chk("async_latch_drop", int'(latch), 0);
      chk("async_buttons_clear", int'(buttons), 8'h00);
      @(negedge clock) reset = 1'b0;
      wait_latch(ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pulse === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("pulse_seen", int'(ok), 1);
      #3 reset = 1'b1;
      #1;
      chk("async_pulse_drop", int'(pulse), 0);
      @(negedge clock) reset = 1'b0;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
